// File: rtl/impulse_pkg.sv
// ---------------------------------------------------------------------------
// impulse_pkg
// Shared types and default constants for the impulse input-conditioning
// stage (impulse_conditioner and its per-channel filter).
//   chan_state_t     : per-channel qualification FSM states
//   *_DEF constants  : default parameter values used by the top and interface
//   level_of()       : filtered level seen by the counter core for a state
// ---------------------------------------------------------------------------
package impulse_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    QUAL_H = 2'd1,
    HIGH   = 2'd2,
    QUAL_L = 2'd3
  } chan_state_t;

  localparam int N_CH_DEF        = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 4;
  localparam int FILT_LEN_DEF    = 3;

  // A channel still reads high while a falling edge is being qualified.
  function automatic logic level_of(chan_state_t st);
    return (st == HIGH) || (st == QUAL_L);
  endfunction

endpackage

// File: rtl/impulse_conditioner_if.sv
// ---------------------------------------------------------------------------
// impulse_conditioner_if
// Groups the raw impulse/RTC inputs and the conditioned outputs of the
// impulse_conditioner into one bundle.
//   ch_in     : raw asynchronous channel inputs          (master -> slave)
//   rtc_in    : raw asynchronous RTC reference input     (master -> slave)
//   ch_pulse  : one-cycle pulse per accepted edge        (slave -> master)
//   ch_level  : filtered channel levels                  (slave -> master)
//   rtc_tick  : one-cycle pulse per RTC rising edge      (slave -> master)
//   event_any : OR of all ch_pulse bits, same cycle      (slave -> master)
// The slave modport is used by the conditioner itself.
// ---------------------------------------------------------------------------
interface impulse_conditioner_if
  import impulse_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
);

  logic [N_CH-1:0] ch_in;
  logic            rtc_in;
  logic [N_CH-1:0] ch_pulse;
  logic [N_CH-1:0] ch_level;
  logic            rtc_tick;
  logic            event_any;

  modport master (
    output ch_in,
    output rtc_in,
    input  ch_pulse,
    input  ch_level,
    input  rtc_tick,
    input  event_any
  );

  modport slave (
    input  ch_in,
    input  rtc_in,
    output ch_pulse,
    output ch_level,
    output rtc_tick,
    output event_any
  );

endinterface

// File: rtl/impulse_chan_filter.sv
// ---------------------------------------------------------------------------
// impulse_chan_filter
// One impulse channel: synchroniser chain, glitch-qualification FSM with its
// run-length counter, and the registered level / pulse outputs.
//   clk, rst_n : clock and asynchronous active-low reset
//   raw_in     : raw asynchronous channel input
//   level      : registered filtered level (1 in HIGH / QUAL_L)
//   pulse      : registered one-cycle pulse per accepted edge
//   pulse_nxt  : value pulse takes at the next edge (feeds event_any)
// Build option IMPULSE_DUAL_EDGE_EN: when defined, the qualified falling edge
// (entry into LOW from the high side) also produces a pulse.
// ---------------------------------------------------------------------------
module impulse_chan_filter
  import impulse_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic pulse,
  output logic pulse_nxt
);

`ifdef IMPULSE_DUAL_EDGE_EN
  localparam logic DUAL_EDGE = 1'b1;
`else
  localparam logic DUAL_EDGE = 1'b0;
`endif

  localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1);
  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  chan_state_t            state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_of(state_d);
      pulse   <= pulse_nxt;
    end
  end

  // The counter holds how many consecutive samples of the new level have
  // been seen; the edge is accepted on the sample that makes it FILT_LEN.
  // With FILT_LEN == 1 the QUAL states are skipped entirely.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_nxt = 1'b0;
    case (state_q)
      LOW: begin
        if (s) begin
          if (FILT_LEN == 1) begin
            state_d   = HIGH;
            pulse_nxt = 1'b1;
          end else begin
            state_d = QUAL_H;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUAL_H: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HIGH;
          cnt_d     = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          if (FILT_LEN == 1) begin
            state_d   = LOW;
            pulse_nxt = DUAL_EDGE;
          end else begin
            state_d = QUAL_L;
            cnt_d   = CNT_ONE;
          end
        end
      end
      QUAL_L: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          pulse_nxt = DUAL_EDGE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/impulse_conditioner.sv
// ---------------------------------------------------------------------------
// impulse_conditioner
// Input-conditioning stage in front of the multi-channel impulse counter.
// Synchronises the raw channel and RTC inputs into clk, glitch-filters each
// channel and emits single-cycle count-enable pulses.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   io    : impulse_conditioner_if.slave
//           ch_in/rtc_in in; ch_pulse/ch_level/rtc_tick/event_any out
// Build option IMPULSE_DUAL_EDGE_EN (handled in impulse_chan_filter): pulse on
// both qualified edges instead of rising edges only.
// ---------------------------------------------------------------------------
module impulse_conditioner
  import impulse_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  impulse_conditioner_if.slave  io
);

  logic [N_CH-1:0]        pulse_q;
  logic [N_CH-1:0]        pulse_nxt;
  logic [N_CH-1:0]        level_q;
  logic                   event_any_q;
  logic [SYNC_STAGES-1:0] rtc_sync_q;
  logic                   rtc_dly_q;
  logic                   rtc_tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    impulse_chan_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_in    (io.ch_in[g]),
      .level     (level_q[g]),
      .pulse     (pulse_q[g]),
      .pulse_nxt (pulse_nxt[g])
    );
  end

  // event_any is registered from the next-state pulses so it lines up with
  // ch_pulse in the same cycle rather than trailing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_any_q <= 1'b0;
    end else begin
      event_any_q <= |pulse_nxt;
    end
  end

  // RTC has no filter: synchroniser, one delay flop, registered rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtc_sync_q <= '0;
      rtc_dly_q  <= 1'b0;
      rtc_tick_q <= 1'b0;
    end else begin
      rtc_sync_q <= {rtc_sync_q[SYNC_STAGES-2:0], io.rtc_in};
      rtc_dly_q  <= rtc_sync_q[SYNC_STAGES-1];
      rtc_tick_q <= rtc_sync_q[SYNC_STAGES-1] & ~rtc_dly_q;
    end
  end

  assign io.ch_pulse  = pulse_q;
  assign io.ch_level  = level_q;
  assign io.event_any = event_any_q;
  assign io.rtc_tick  = rtc_tick_q;

endmodule

// File: tb/tb_impulse_conditioner.sv
// ---------------------------------------------------------------------------
// tb_impulse_conditioner
// Directed self-checking bench for impulse_conditioner with default
// parameters. Cycle index c counts sampling points: c = 0 is just after the
// first rising edge that sees a newly applied input.
// ---------------------------------------------------------------------------
module tb_impulse_conditioner;

  localparam int N_CH = 8;

`ifdef IMPULSE_DUAL_EDGE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   num_compared;
  int   num_mismatched;

  impulse_conditioner_if #(.N_CH(N_CH)) io ();

  impulse_conditioner #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .FILT_W      (4),
    .FILT_LEN    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] ch, input logic rtc);
    io.ch_in  = ch;
    io.rtc_in = rtc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Raise 'mask', hold it for high_cycles sampling points, then drop it, and
  // check pulse/level/event_any at every point against the given windows.
  task automatic runWindow(input string name, input logic [N_CH-1:0] mask,
                           input int high_cycles, input int n_cycles,
                           input int rise_at, input int fall_at,
                           input int level_from, input int level_to);
    logic [N_CH-1:0] exp_pulse;
    logic [N_CH-1:0] exp_level;
    applyStimulus(mask, 1'b0);
    for (int c = 0; c < n_cycles; c++) begin
      tick(1);
      exp_pulse = (c == rise_at || c == fall_at) ? mask : '0;
      exp_level = (c >= level_from && c < level_to) ? mask : '0;
      checkOutput($sformatf("%s c%0d ch_pulse", name, c), 32'(io.ch_pulse), 32'(exp_pulse));
      checkOutput($sformatf("%s c%0d ch_level", name, c), 32'(io.ch_level), 32'(exp_level));
      checkOutput($sformatf("%s c%0d event_any", name, c), 32'(io.event_any), 32'(|exp_pulse));
      if (c == high_cycles - 1) applyStimulus('0, 1'b0);
    end
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b0);

    // Reset with all inputs high: everything held at zero.
    tick(3);
    checkOutput("reset ch_pulse", 32'(io.ch_pulse), 32'h0);
    checkOutput("reset ch_level", 32'(io.ch_level), 32'h0);
    checkOutput("reset rtc_tick", 32'(io.rtc_tick), 32'h0);
    checkOutput("reset event_any", 32'(io.event_any), 32'h0);

    // Release: inputs held high count as a new edge, one pulse each.
    rst_n = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick(1);
      checkOutput($sformatf("release c%0d ch_pulse", c), 32'(io.ch_pulse),
                  (c == 4) ? 32'hFF : 32'h0);
      checkOutput($sformatf("release c%0d ch_level", c), 32'(io.ch_level),
                  (c >= 4) ? 32'hFF : 32'h0);
      checkOutput($sformatf("release c%0d event_any", c), 32'(io.event_any),
                  (c == 4) ? 32'h1 : 32'h0);
    end
    applyStimulus('0, 1'b0);
    tick(8);
    checkOutput("settle ch_level", 32'(io.ch_level), 32'h0);

    // Clean 10-cycle pulse on channel 2.
    runWindow("clean", 8'h04, 10, 18, 4, DUAL ? 14 : -1, 4, 14);

    // 2-cycle glitch on channel 5 is rejected, 3-cycle high is accepted.
    runWindow("glitch2", 8'h20, 2, 10, -1, -1, 0, 0);
    runWindow("high3", 8'h20, 3, 10, 4, DUAL ? 7 : -1, 4, 7);

    // Spec's dual-edge vector on channel 7 (rising only in default build).
    runWindow("ch7x8", 8'h80, 8, 15, 4, DUAL ? 12 : -1, 4, 12);

    // Low glitch while channel 1 is high is rejected.
    applyStimulus(8'h02, 1'b0);
    tick(8);
    applyStimulus('0, 1'b0);
    tick(2);
    applyStimulus(8'h02, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checkOutput($sformatf("lowglitch c%0d ch_pulse", c), 32'(io.ch_pulse), 32'h0);
      checkOutput($sformatf("lowglitch c%0d ch_level", c), 32'(io.ch_level), 32'h02);
    end
    applyStimulus('0, 1'b0);
    tick(8);

    // Simultaneous channel and RTC rising edges.
    applyStimulus(8'hA5, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checkOutput($sformatf("simul c%0d rtc_tick", c), 32'(io.rtc_tick),
                  (c == 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("simul c%0d ch_pulse", c), 32'(io.ch_pulse),
                  (c == 4) ? 32'hA5 : 32'h0);
      checkOutput($sformatf("simul c%0d event_any", c), 32'(io.event_any),
                  (c == 4) ? 32'h1 : 32'h0);
    end
    applyStimulus('0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checkOutput($sformatf("rtcfall c%0d rtc_tick", c), 32'(io.rtc_tick), 32'h0);
    end

    // Reset in the middle of qualifying channel 0.
    applyStimulus(8'h01, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checkOutput($sformatf("midq c%0d ch_pulse", c), 32'(io.ch_pulse), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midq in reset ch_level", 32'(io.ch_level), 32'h0);
    checkOutput("midq in reset ch_pulse", 32'(io.ch_pulse), 32'h0);
    tick(1);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick(1);
      checkOutput($sformatf("midq rel c%0d ch_pulse", c), 32'(io.ch_pulse),
                  (c == 4) ? 32'h01 : 32'h0);
      checkOutput($sformatf("midq rel c%0d ch_level", c), 32'(io.ch_level),
                  (c >= 4) ? 32'h01 : 32'h0);
    end
    applyStimulus('0, 1'b0);
    tick(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
